// File: rtl/regfile_wb_arbiter.sv
// Purpose : arbitrates two writeback ports (ALU, load) onto one register-file write
//           port and keeps a pending-write scoreboard for hazard queries.
// Latency : a writeback accepted in cycle N is driven on rf_* in cycle N+1.
// Backpressure: ready is combinational; only the granted port sees ready, and the
//           loser holds its request until granted.
//
// Ports:
//   clock_i, resetb_i              clock, synchronous active-low reset
//   issue_valid_i, issue_rd_i      marks issue_rd_i as having a pending write
//   rs1_i, rs2_i / busy1_o, busy2_o  hazard queries against the scoreboard
//   wb0_* (ALU), wb1_* (load)      valid/ready writeback requests
//   rf_wena_o, rf_wadr_o, rf_wdata_o  registered register-file write port
//   sb_err_o                       sticky: writeback to a register not pending
module regfile_wb_arbiter #(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic        clock_i,
    input  logic        resetb_i,
    input  logic        issue_valid_i,
    input  logic [4:0]  issue_rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    output logic        busy1_o,
    output logic        busy2_o,
    input  logic        wb0_valid_i,
    input  logic [4:0]  wb0_rd_i,
    input  logic [31:0] wb0_data_i,
    output logic        wb0_ready_o,
    input  logic        wb1_valid_i,
    input  logic [4:0]  wb1_rd_i,
    input  logic [31:0] wb1_data_i,
    output logic        wb1_ready_o,
    output logic        rf_wena_o,
    output logic [4:0]  rf_wadr_o,
    output logic [31:0] rf_wdata_o,
    output logic        sb_err_o
);

    logic [31:0] sb;
    logic        last_grant;   // port that won the most recent transfer

    logic        gnt0;
    logic        gnt1;
    logic        xfer;
    logic [4:0]  sel_rd;
    logic [31:0] sel_data;
    logic        sel_wr;
    logic [31:0] sb_set;
    logic [31:0] sb_clr;
    logic [31:0] sb_next;
    logic        err_hit;

    // Grants only go to valid requesters, so a grant is itself a transfer.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (resetb_i) begin
            if (wb0_valid_i && wb1_valid_i) begin
                if (RR_ENABLE && !last_grant) begin
                    gnt1 = 1'b1;
                end else begin
                    gnt0 = 1'b1;
                end
            end else if (wb0_valid_i) begin
                gnt0 = 1'b1;
            end else if (wb1_valid_i) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign wb0_ready_o = gnt0;
    assign wb1_ready_o = gnt1;
    assign xfer        = gnt0 | gnt1;
    assign sel_rd      = gnt1 ? wb1_rd_i   : wb0_rd_i;
    assign sel_data    = gnt1 ? wb1_data_i : wb0_data_i;

    // x0 writebacks are accepted but never reach the register file.
    assign sel_wr  = xfer && (sel_rd != 5'd0);
    assign err_hit = sel_wr && !sb[sel_rd];

    // Clear follows the registered write; set is applied after clear so a
    // same-register issue in the write cycle keeps the bit pending.
    assign sb_set  = (issue_valid_i && (issue_rd_i != 5'd0)) ? (32'd1 << issue_rd_i) : 32'd0;
    assign sb_clr  = rf_wena_o ? (32'd1 << rf_wadr_o) : 32'd0;
    assign sb_next = ((sb & ~sb_clr) | sb_set) & ~32'd1;

    // sb[0] is never set, so an x0 query always reads as not busy.
    assign busy1_o = sb[rs1_i];
    assign busy2_o = sb[rs2_i];

    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            sb         <= 32'd0;
            last_grant <= 1'b1;
            rf_wena_o  <= 1'b0;
            rf_wadr_o  <= 5'd0;
            rf_wdata_o <= 32'd0;
            sb_err_o   <= 1'b0;
        end else begin
            sb        <= sb_next;
            rf_wena_o <= sel_wr;
            if (sel_wr) begin
                rf_wadr_o  <= sel_rd;
                rf_wdata_o <= sel_data;
            end
            if (xfer) begin
                last_grant <= gnt1;
            end
            if (err_hit) begin
                sb_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Purpose : directed scoreboard bench for regfile_wb_arbiter, round-robin and
//           fixed-priority instances driven by the same stimulus.
// Latency : expected register-file writes are queued at transfer time and popped
//           by a negedge monitor whenever rf_wena_o is seen high.
module tb_regfile_wb_arbiter;

    typedef struct packed {
        logic [4:0]  adr;
        logic [31:0] dat;
    } wr_t;

    logic        clk = 1'b0;
    logic        resetb;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        wb0_valid;
    logic [4:0]  wb0_rd;
    logic [31:0] wb0_data;
    logic        wb1_valid;
    logic [4:0]  wb1_rd;
    logic [31:0] wb1_data;

    logic        rr_busy1, rr_busy2, rr_ready0, rr_ready1, rr_wena, rr_err;
    logic [4:0]  rr_wadr;
    logic [31:0] rr_wdata;
    logic        fp_busy1, fp_busy2, fp_ready0, fp_ready1, fp_wena, fp_err;
    logic [4:0]  fp_wadr;
    logic [31:0] fp_wdata;

    wr_t q_rr[$];
    wr_t q_fp[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    bit  mon_en   = 1'b0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.RR_ENABLE(1'b1)) u_rr (
        .clock_i(clk), .resetb_i(resetb),
        .issue_valid_i(issue_valid), .issue_rd_i(issue_rd),
        .rs1_i(rs1), .rs2_i(rs2), .busy1_o(rr_busy1), .busy2_o(rr_busy2),
        .wb0_valid_i(wb0_valid), .wb0_rd_i(wb0_rd), .wb0_data_i(wb0_data), .wb0_ready_o(rr_ready0),
        .wb1_valid_i(wb1_valid), .wb1_rd_i(wb1_rd), .wb1_data_i(wb1_data), .wb1_ready_o(rr_ready1),
        .rf_wena_o(rr_wena), .rf_wadr_o(rr_wadr), .rf_wdata_o(rr_wdata), .sb_err_o(rr_err)
    );

    regfile_wb_arbiter #(.RR_ENABLE(1'b0)) u_fp (
        .clock_i(clk), .resetb_i(resetb),
        .issue_valid_i(issue_valid), .issue_rd_i(issue_rd),
        .rs1_i(rs1), .rs2_i(rs2), .busy1_o(fp_busy1), .busy2_o(fp_busy2),
        .wb0_valid_i(wb0_valid), .wb0_rd_i(wb0_rd), .wb0_data_i(wb0_data), .wb0_ready_o(fp_ready0),
        .wb1_valid_i(wb1_valid), .wb1_rd_i(wb1_rd), .wb1_data_i(wb1_data), .wb1_ready_o(fp_ready1),
        .rf_wena_o(fp_wena), .rf_wadr_o(fp_wadr), .rf_wdata_o(fp_wdata), .sb_err_o(fp_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        issue_valid = 1'b0; issue_rd = 5'd0;
        wb0_valid = 1'b0; wb0_rd = 5'd0; wb0_data = 32'd0;
        wb1_valid = 1'b0; wb1_rd = 5'd0; wb1_data = 32'd0;
    endtask

    task automatic reset_dut();
        resetb = 1'b0;
        clear_inputs();
        tick();
        tick();
        resetb = 1'b1;
    endtask

    task automatic push_both(input logic [4:0] a, input logic [31:0] d);
        q_rr.push_back('{adr: a, dat: d});
        q_fp.push_back('{adr: a, dat: d});
    endtask

    // Register-file write monitors
    always @(negedge clk) begin
        if (mon_en && rr_wena !== 1'b0) begin
            if (q_rr.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rr_unexpected_write: got adr %0d data 0x%0h, none expected", rr_wadr, rr_wdata);
            end else begin
                wr_t e;
                e = q_rr.pop_front();
                chk("rr_wadr", {27'd0, rr_wadr}, {27'd0, e.adr});
                chk("rr_wdata", rr_wdata, e.dat);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en && fp_wena !== 1'b0) begin
            if (q_fp.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL fp_unexpected_write: got adr %0d data 0x%0h, none expected", fp_wadr, fp_wdata);
            end else begin
                wr_t e;
                e = q_fp.pop_front();
                chk("fp_wadr", {27'd0, fp_wadr}, {27'd0, e.adr});
                chk("fp_wdata", fp_wdata, e.dat);
            end
        end
    end

    initial begin
        clear_inputs();
        rs1 = 5'd3;
        rs2 = 5'd0;
        // Reset with requests and an issue present: reset must dominate.
        resetb = 1'b0;
        wb0_valid = 1'b1; wb0_rd = 5'd3; wb0_data = 32'h33;
        wb1_valid = 1'b1; wb1_rd = 5'd4; wb1_data = 32'h44;
        issue_valid = 1'b1; issue_rd = 5'd3;
        tick();
        tick();
        mon_en = 1'b1;
        chk("rst_rr_ready0", {31'd0, rr_ready0}, 32'd0);
        chk("rst_rr_ready1", {31'd0, rr_ready1}, 32'd0);
        chk("rst_fp_ready0", {31'd0, fp_ready0}, 32'd0);
        chk("rst_wena", {31'd0, rr_wena}, 32'd0);
        chk("rst_wadr", {27'd0, rr_wadr}, 32'd0);
        chk("rst_wdata", rr_wdata, 32'd0);
        chk("rst_err", {31'd0, rr_err}, 32'd0);
        chk("rst_busy3", {31'd0, rr_busy1}, 32'd0);
        clear_inputs();
        resetb = 1'b1;
        tick();

        // Issue x5, writeback x5 two cycles later
        issue_valid = 1'b1; issue_rd = 5'd5; rs1 = 5'd5;
        #1 chk("c1_busy5", {31'd0, rr_busy1}, 32'd0);
        tick();
        issue_valid = 1'b0;
        #1 chk("c2_busy5", {31'd0, rr_busy1}, 32'd1);
        chk("c2_busy_x0", {31'd0, rr_busy2}, 32'd0);
        tick();
        wb0_valid = 1'b1; wb0_rd = 5'd5; wb0_data = 32'hDEADBEEF;
        push_both(5'd5, 32'hDEADBEEF);
        #1 chk("c3_ready0", {31'd0, rr_ready0}, 32'd1);
        chk("c3_ready1", {31'd0, rr_ready1}, 32'd0);
        chk("c3_busy5", {31'd0, fp_busy1}, 32'd1);
        tick();
        wb0_valid = 1'b0;
        #1 chk("c4_busy5", {31'd0, rr_busy1}, 32'd1);
        tick();
        chk("c5_busy5", {31'd0, rr_busy1}, 32'd0);
        chk("c5_err", {31'd0, rr_err}, 32'd0);

        // Issue x7 in the same cycle the write of x7 is on the port: set wins
        issue_valid = 1'b1; issue_rd = 5'd7; rs1 = 5'd7;
        tick();
        issue_valid = 1'b0;
        wb0_valid = 1'b1; wb0_rd = 5'd7; wb0_data = 32'h77;
        push_both(5'd7, 32'h77);
        tick();
        wb0_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        chk("set_wins_busy7", {31'd0, rr_busy1}, 32'd1);
        chk("set_wins_err", {31'd0, rr_err}, 32'd0);
        tick();
        chk("set_wins_busy7_hold", {31'd0, fp_busy1}, 32'd1);
        wb1_valid = 1'b1; wb1_rd = 5'd7; wb1_data = 32'h7007;
        push_both(5'd7, 32'h7007);
        #1 chk("lone_wb1_ready", {31'd0, rr_ready1}, 32'd1);
        chk("lone_wb1_ready_fp", {31'd0, fp_ready1}, 32'd1);
        tick();
        wb1_valid = 1'b0;
        tick();
        chk("x7_cleared", {31'd0, rr_busy1}, 32'd0);

        // Both ports requesting for 4 cycles from a fresh reset
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            wb0_valid = 1'b1; wb0_rd = 5'd1; wb0_data = 32'h100 + i;
            wb1_valid = 1'b1; wb1_rd = 5'd2; wb1_data = 32'h200 + i;
            if (i % 2 == 0) q_rr.push_back('{adr: 5'd1, dat: 32'h100 + i});
            else            q_rr.push_back('{adr: 5'd2, dat: 32'h200 + i});
            q_fp.push_back('{adr: 5'd1, dat: 32'h100 + i});
            #1;
            chk("rr_conf_ready0", {31'd0, rr_ready0}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_conf_ready1", {31'd0, rr_ready1}, (i % 2 == 1) ? 32'd1 : 32'd0);
            chk("fp_conf_ready0", {31'd0, fp_ready0}, 32'd1);
            chk("fp_conf_ready1", {31'd0, fp_ready1}, 32'd0);
            tick();
        end
        clear_inputs();
        tick();

        // x0 writeback: accepted, no write, outputs hold, no error
        reset_dut();
        issue_valid = 1'b1; issue_rd = 5'd4; rs2 = 5'd4;
        tick();
        issue_valid = 1'b0;
        wb0_valid = 1'b1; wb0_rd = 5'd4; wb0_data = 32'hAA;
        push_both(5'd4, 32'hAA);
        tick();
        wb0_valid = 1'b0;
        tick();
        wb1_valid = 1'b1; wb1_rd = 5'd0; wb1_data = 32'h1234; rs1 = 5'd0;
        #1 chk("x0_ready1", {31'd0, rr_ready1}, 32'd1);
        tick();
        wb1_valid = 1'b0;
        #1 chk("x0_rr_wena", {31'd0, rr_wena}, 32'd0);
        chk("x0_fp_wena", {31'd0, fp_wena}, 32'd0);
        chk("x0_wadr_hold", {27'd0, rr_wadr}, 32'd4);
        chk("x0_wdata_hold", rr_wdata, 32'hAA);
        chk("x0_err", {31'd0, rr_err}, 32'd0);
        chk("x0_busy0", {31'd0, rr_busy1}, 32'd0);
        chk("x4_cleared", {31'd0, rr_busy2}, 32'd0);
        tick();

        // Writeback to x9 that was never issued: written, error sticks
        wb0_valid = 1'b1; wb0_rd = 5'd9; wb0_data = 32'h99;
        push_both(5'd9, 32'h99);
        #1 chk("err_before", {31'd0, rr_err}, 32'd0);
        tick();
        wb0_valid = 1'b0;
        chk("err_set_rr", {31'd0, rr_err}, 32'd1);
        chk("err_set_fp", {31'd0, fp_err}, 32'd1);
        tick();
        tick();
        tick();
        chk("err_sticky", {31'd0, rr_err}, 32'd1);

        // Reset in the same cycle as an issue and a writeback
        resetb = 1'b0;
        wb0_valid = 1'b1; wb0_rd = 5'd3; wb0_data = 32'h3333;
        issue_valid = 1'b1; issue_rd = 5'd3; rs1 = 5'd3;
        #1 chk("rst_mid_ready0", {31'd0, rr_ready0}, 32'd0);
        tick();
        clear_inputs();
        resetb = 1'b1;
        #1 chk("rst_mid_wena", {31'd0, rr_wena}, 32'd0);
        chk("rst_mid_err", {31'd0, rr_err}, 32'd0);
        chk("rst_mid_busy3", {31'd0, rr_busy1}, 32'd0);
        tick();
        tick();

        chk("rr_queue_drained", q_rr.size(), 32'd0);
        chk("fp_queue_drained", q_fp.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
